// File: rtl/lif_array_scheduler_pkg.sv
// Shared widths, FSM encodings, operand bundle and saturation helper for the
// time-multiplexed LIF neuron array.
package lif_array_scheduler_pkg;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_UPDATE = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] state;
    logic [DATA_W-1:0] leak;
    logic [DATA_W-1:0] thr;
  } lif_operands_t;

  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(255);

  function automatic logic [DATA_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])   return '0;
    else if (v > SUM_MAX) return {DATA_W{1'b1}};
    else              return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/lif_array_scheduler_if.sv
// Bus bundle for the LIF array: current/threshold config, sweep control,
// spike event handshake and the debug state read port.
interface lif_array_scheduler_if
  import lif_array_scheduler_pkg::*;
#(
  parameter int ID_W = 2
);
  logic              cur_we;
  logic [ID_W-1:0]   cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              thr_we;
  logic [DATA_W-1:0] thr_data;
  logic              step_start;
  logic              step_busy;
  logic              step_done;
  logic              spk_valid;
  logic [ID_W-1:0]   spk_id;
  logic              spk_ready;
  logic [ID_W-1:0]   rd_addr;
  logic [DATA_W-1:0] rd_state;

  modport master (
    output cur_we, cur_addr, cur_data, thr_we, thr_data, step_start, spk_ready, rd_addr,
    input  step_busy, step_done, spk_valid, spk_id, rd_state
  );

  modport slave (
    input  cur_we, cur_addr, cur_data, thr_we, thr_data, step_start, spk_ready, rd_addr,
    output step_busy, step_done, spk_valid, spk_id, rd_state
  );
endinterface

// File: rtl/lif_array_scheduler_update_core.sv
// Combinational LIF update: spike decision on the pre-update state, decay,
// leak growth and saturation of the new membrane state.
module lif_array_scheduler_update_core
  import lif_array_scheduler_pkg::*;
#(
  parameter int BETA_NUM   = 1,
  parameter int BETA_SHIFT = 1,
  parameter int LEAK_INC   = 1
) (
  input  lif_operands_t     ops,
  output logic [DATA_W-1:0] next_state,
  output logic [DATA_W-1:0] next_leak,
  output logic              spk
);
  localparam int PROD_W = DATA_W + 16;

  logic        [PROD_W-1:0] prod;
  logic        [DATA_W-1:0] decay;
  logic signed [SUM_W-1:0]  sum;
  logic        [DATA_W:0]   leak_inc;

  always_comb begin
    spk        = (ops.state >= ops.thr);
    prod       = PROD_W'(ops.state) * PROD_W'(BETA_NUM);
    decay      = spk ? '0 : DATA_W'(prod >> BETA_SHIFT);
    sum        = $signed(SUM_W'(ops.cur)) + $signed(SUM_W'(decay)) - $signed(SUM_W'(ops.leak));
    leak_inc   = {1'b0, ops.leak} + (DATA_W + 1)'(LEAK_INC);
    next_state = clamp_u8(sum);
    // A firing neuron restarts its leak; otherwise leak saturates at full scale.
    next_leak  = spk ? '0 : (leak_inc[DATA_W] ? {DATA_W{1'b1}} : leak_inc[DATA_W-1:0]);
  end
endmodule

// File: rtl/lif_array_scheduler.sv
// Sweeps one shared LIF update core across N_NEURONS virtual neurons held in
// register files, emitting spike ids on a valid/ready port.
module lif_array_scheduler
  import lif_array_scheduler_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int ID_W       = 2,
  parameter int THRESH_RST = 200,
  parameter int BETA_NUM   = 1,
  parameter int BETA_SHIFT = 1,
  parameter int LEAK_INC   = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  lif_array_scheduler_if.slave  bus
);
  logic [DATA_W-1:0] state_mem [N_NEURONS];
  logic [DATA_W-1:0] leak_mem  [N_NEURONS];
  logic [DATA_W-1:0] cur_mem   [N_NEURONS];
  logic [DATA_W-1:0] thr_q;
  logic [2:0]        fsm;
  logic [ID_W-1:0]   idx;
  lif_operands_t     ops_p0;
  logic [DATA_W-1:0] next_state;
  logic [DATA_W-1:0] next_leak;
  logic              spk;
  logic              last_idx;
  logic              cur_addr_ok;
  logic              rd_addr_ok;

  lif_array_scheduler_update_core #(
    .BETA_NUM   (BETA_NUM),
    .BETA_SHIFT (BETA_SHIFT),
    .LEAK_INC   (LEAK_INC)
  ) u_core (
    .ops        (ops_p0),
    .next_state (next_state),
    .next_leak  (next_leak),
    .spk        (spk)
  );

  assign last_idx    = (idx == ID_W'(N_NEURONS - 1));
  assign cur_addr_ok = ({1'b0, bus.cur_addr} < (ID_W + 1)'(N_NEURONS));
  assign rd_addr_ok  = ({1'b0, bus.rd_addr}  < (ID_W + 1)'(N_NEURONS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm   <= ST_IDLE;
      idx   <= '0;
      thr_q <= DATA_W'(THRESH_RST);
      for (int i = 0; i < N_NEURONS; i++) begin
        state_mem[i] <= '0;
        leak_mem[i]  <= '0;
        cur_mem[i]   <= '0;
      end
    end else begin
      if (bus.thr_we) thr_q <= bus.thr_data;
      if (bus.cur_we && cur_addr_ok) cur_mem[bus.cur_addr] <= bus.cur_data;
      case (fsm)
        ST_IDLE: begin
          if (bus.step_start) begin
            idx <= '0;
            fsm <= ST_READ;
          end
        end
        ST_READ: fsm <= ST_UPDATE;
        ST_UPDATE: begin
          state_mem[idx] <= next_state;
          leak_mem[idx]  <= next_leak;
          if (spk)           fsm <= ST_EMIT;
          else if (last_idx) fsm <= ST_DONE;
          else begin
            idx <= idx + 1'b1;
            fsm <= ST_READ;
          end
        end
        ST_EMIT: begin
          if (bus.spk_ready) begin
            if (last_idx) fsm <= ST_DONE;
            else begin
              idx <= idx + 1'b1;
              fsm <= ST_READ;
            end
          end
        end
        ST_DONE: fsm <= ST_IDLE;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: operands of the current neuron, stable through UPDATE and EMIT.
  always_ff @(posedge clk) begin
    if (fsm == ST_READ) begin
      ops_p0.cur   <= cur_mem[idx];
      ops_p0.state <= state_mem[idx];
      ops_p0.leak  <= leak_mem[idx];
      ops_p0.thr   <= thr_q;
    end
  end

  assign bus.step_busy = (fsm != ST_IDLE);
  assign bus.step_done = (fsm == ST_DONE);
  assign bus.spk_valid = (fsm == ST_EMIT);
  assign bus.spk_id    = idx;
  assign bus.rd_state  = rd_addr_ok ? state_mem[bus.rd_addr] : '0;

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Randomised bench for lif_array_scheduler against an arithmetic neuron model.
module tb_lif_array_scheduler;
  localparam int N          = 4;
  localparam int ID_W       = 2;
  localparam int THR_RST    = 200;
  localparam int BETA_NUM   = 1;
  localparam int BETA_SHIFT = 1;
  localparam int LEAK_INC   = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vec = 0;
  int   errs = 0;

  int m_st [N];
  int m_lk [N];
  int m_cu [N];
  int m_thr;
  int exp_q [$];

  lif_array_scheduler_if #(.ID_W(ID_W)) bus ();

  lif_array_scheduler #(
    .N_NEURONS  (N),
    .ID_W       (ID_W),
    .THRESH_RST (THR_RST),
    .BETA_NUM   (BETA_NUM),
    .BETA_SHIFT (BETA_SHIFT),
    .LEAK_INC   (LEAK_INC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_lk[i] = 0;
      m_cu[i] = 0;
    end
    m_thr = THR_RST;
  endfunction

  function automatic void model_sweep();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int  s;
      int  d;
      int  ns;
      bit  fire;
      s    = m_st[i];
      fire = (s >= m_thr);
      d    = fire ? 0 : ((s * BETA_NUM) >> BETA_SHIFT);
      ns   = m_cu[i] + d - m_lk[i];
      if (ns < 0)   ns = 0;
      if (ns > 255) ns = 255;
      m_lk[i] = fire ? 0 : ((m_lk[i] + LEAK_INC > 255) ? 255 : m_lk[i] + LEAK_INC);
      m_st[i] = ns;
      if (fire) exp_q.push_back(i);
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic write_cur(input int a, input int v);
    bus.cur_we   = 1'b1;
    bus.cur_addr = ID_W'(a);
    bus.cur_data = 8'(v);
    @(posedge clk);
    #1;
    bus.cur_we = 1'b0;
    m_cu[a] = v;
  endtask

  task automatic write_thr(input int v);
    bus.thr_we   = 1'b1;
    bus.thr_data = 8'(v);
    @(posedge clk);
    #1;
    bus.thr_we = 1'b0;
    m_thr = v;
  endtask

  task automatic check_states(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_addr = ID_W'(i);
      #1;
      vec++;
      if (bus.rd_state !== 8'(m_st[i])) begin
        errs++;
        $display("FAIL %s state[%0d]: got %0d expected %0d", tag, i, bus.rd_state, m_st[i]);
      end
    end
  endtask

  // Runs one sweep; done_at counts cycles from the cycle in which start was driven.
  task automatic run_sweep(input string tag, input int ready_pct, input int stall_first,
                           input bit poke, output int done_at, output int n_evt);
    int n;
    int stall_left;
    int stalls;
    int held_id;
    bit holding;
    int exp_done;
    model_sweep();
    n_evt = 0; done_at = -1; stall_left = stall_first; stalls = 0; holding = 0; held_id = 0;
    bus.spk_ready  = 1'b0;
    bus.step_start = 1'b1;
    @(posedge clk);
    #1;
    bus.step_start = 1'b0;
    n = 1;
    vec++;
    if (bus.step_busy !== 1'b1) begin
      errs++;
      $display("FAIL %s busy_rise: got %b expected 1", tag, bus.step_busy);
    end
    while (done_at < 0 && n < 300) begin
      bus.step_start = (poke && n == 3);
      if (bus.spk_valid === 1'b1) begin
        if (holding) begin
          vec++;
          if (bus.spk_id !== ID_W'(held_id)) begin
            errs++;
            $display("FAIL %s spk_id_stable: got %0d expected %0d", tag, bus.spk_id, held_id);
          end
        end
        if (stall_left > 0) begin
          bus.spk_ready = 1'b0;
          stall_left--;
        end else begin
          bus.spk_ready = ($urandom_range(99) < ready_pct);
        end
        if (bus.spk_ready) begin
          vec++;
          if (n_evt >= exp_q.size()) begin
            errs++;
            $display("FAIL %s extra_spike: got id %0d expected none", tag, bus.spk_id);
          end else if (bus.spk_id !== ID_W'(exp_q[n_evt])) begin
            errs++;
            $display("FAIL %s spike_id: got %0d expected %0d", tag, bus.spk_id, exp_q[n_evt]);
          end
          n_evt++;
          holding = 1'b0;
        end else begin
          stalls++;
          holding = 1'b1;
          held_id = int'(bus.spk_id);
        end
      end else begin
        bus.spk_ready = 1'($urandom_range(1));
      end
      if (bus.step_done === 1'b1) done_at = n;
      @(posedge clk);
      #1;
      n++;
    end
    bus.step_start = 1'b0;
    bus.spk_ready  = 1'b0;
    exp_done = 2 * N + 1 + exp_q.size() + stalls;
    vec++;
    if (done_at != exp_done) begin
      errs++;
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_at, exp_done);
    end
    vec++;
    if (n_evt != exp_q.size()) begin
      errs++;
      $display("FAIL %s spike_count: got %0d expected %0d", tag, n_evt, exp_q.size());
    end
    vec++;
    if (bus.step_done !== 1'b0 || bus.step_busy !== 1'b0) begin
      errs++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", tag, bus.step_done, bus.step_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    vec++;
    if (bus.step_busy !== 1'b0 || bus.spk_valid !== 1'b0 || bus.step_done !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got busy=%b valid=%b done=%b expected 0 0 0",
               bus.step_busy, bus.spk_valid, bus.step_done);
    end
    check_states("reset");
    reset_n = 1'b1;
  endtask

  task automatic test_timing();
    int d;
    int e;
    do_reset();
    run_sweep("timing", 100, 0, 1'b0, d, e);
    vec++;
    if (d != 9) begin
      errs++;
      $display("FAIL timing_latency: got %0d expected 9", d);
    end
    check_states("timing");
  endtask

  task automatic test_integrate_fire();
    int d;
    int e;
    int want [3];
    want = '{150, 224, 148};
    do_reset();
    write_cur(0, 150);
    for (int s = 0; s < 3; s++) begin
      run_sweep("integrate", 100, 0, 1'b0, d, e);
      bus.rd_addr = '0;
      #1;
      vec++;
      if (bus.rd_state !== 8'(want[s]) || e != (s == 2 ? 1 : 0)) begin
        errs++;
        $display("FAIL integrate_step%0d: got state %0d events %0d expected %0d %0d",
                 s + 1, bus.rd_state, e, want[s], (s == 2 ? 1 : 0));
      end
    end
  endtask

  task automatic test_backpressure();
    int d;
    int e;
    do_reset();
    write_cur(0, 150);
    run_sweep("bp_pre1", 100, 0, 1'b0, d, e);
    run_sweep("bp_pre2", 100, 0, 1'b0, d, e);
    run_sweep("backpressure", 100, 5, 1'b0, d, e);
    vec++;
    if (d != 15 || e != 1) begin
      errs++;
      $display("FAIL backpressure: got done %0d events %0d expected 15 1", d, e);
    end
    check_states("backpressure");
  endtask

  task automatic test_clamps();
    int d;
    int e;
    do_reset();
    write_cur(0, 150);
    run_sweep("clamp1", 100, 0, 1'b0, d, e);
    write_cur(0, 255);
    run_sweep("clamp_hi", 100, 0, 1'b0, d, e);
    bus.rd_addr = '0;
    #1;
    vec++;
    if (bus.rd_state !== 8'd255) begin
      errs++;
      $display("FAIL clamp_high: got %0d expected 255", bus.rd_state);
    end
    write_cur(0, 0);
    run_sweep("clamp_lo", 100, 0, 1'b0, d, e);
    bus.rd_addr = '0;
    #1;
    vec++;
    if (bus.rd_state !== 8'd0) begin
      errs++;
      $display("FAIL clamp_low: got %0d expected 0", bus.rd_state);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int d;
    int e;
    do_reset();
    for (int i = 0; i < N; i++) write_cur(i, 120 + 40 * i);
    run_sweep("mid_pre", 100, 0, 1'b0, d, e);
    bus.spk_ready  = 1'b1;
    bus.step_start = 1'b1;
    @(posedge clk);
    #1;
    bus.step_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) reset_n = 1'b1;
      vec++;
      if (bus.step_done !== 1'b0 || bus.spk_valid !== 1'b0) begin
        errs++;
        $display("FAIL mid_reset_quiet cycle %0d: got done=%b valid=%b expected 0 0",
                 c, bus.step_done, bus.spk_valid);
      end
    end
    bus.spk_ready = 1'b0;
    model_reset();
    check_states("mid_reset_zero");
    write_cur(0, 150);
    run_sweep("mid_post", 100, 0, 1'b0, d, e);
    bus.rd_addr = '0;
    #1;
    vec++;
    if (bus.rd_state !== 8'd150) begin
      errs++;
      $display("FAIL mid_reset_restart: got %0d expected 150", bus.rd_state);
    end
    check_states("mid_post");
  endtask

  task automatic test_random();
    int d;
    int e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) write_cur(i, int'($urandom_range(255)));
      if (k % 3 == 2) write_thr(int'($urandom_range(255, 40)));
      run_sweep("random", 60, (k % 4 == 1) ? 2 : 0, (k % 5 == 1), d, e);
      check_states("random");
    end
  endtask

  initial begin
    bus.cur_we = 1'b0; bus.cur_addr = '0; bus.cur_data = '0;
    bus.thr_we = 1'b0; bus.thr_data = '0;
    bus.step_start = 1'b0; bus.spk_ready = 1'b0; bus.rd_addr = '0;
    model_reset();
    test_reset();
    test_timing();
    test_integrate_fire();
    test_backpressure();
    test_clamps();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
